// File: rtl/dac_pkg.sv
// Shared constants for the DAC SPI transmitter: FSM encoding and frame geometry.
package dac_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] HOLD  = 2'd3;

   localparam int FRAME_BITS    = 16;
   localparam int DAC_DATA_BITS = 12;

   // unbuffered, gain 1x, active
   localparam logic [3:0] CTRL_BITS_DEFAULT = 4'b0011;
endpackage

// File: rtl/dac_spi_tx_tick.sv
// Half-period tick counter: counts 0..CLK_DIV-1, ticks on the last count, held at 0 by restart.
module spi_clk_tick
   import dac_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (restart || count == LAST)
         count <= '0;
      else
         count <= count + CW'(1);
   end

   assign tick = (count == LAST) && !restart;
endmodule

// File: rtl/dac_spi_tx.sv
// Serialises one sine sample per frame as {control nibble, 12 data bits} to an SPI DAC (mode 0).
// state | meaning
// IDLE  | ready for a sample, cs_n high
// SETUP | cs_n low, first bit on mosi, sclk low
// SHIFT | 16 bits, sclk high then low half-periods
// HOLD  | cs_n high guard time before ready
module dac_spi_tx
   import dac_pkg::*;
#(
   parameter int         SINE_SIZE = 12,
   parameter int         CLK_DIV   = 4,
   parameter logic [3:0] CTRL_BITS = CTRL_BITS_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [SINE_SIZE-1:0] sample,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 sclk,
   output logic                 mosi,
   output logic                 cs_n,
   output logic                 busy,
   output logic                 frame_done
);
   logic [1:0]               state;
   logic [FRAME_BITS-1:0]    shreg;
   logic [3:0]               bit_cnt;
   logic [DAC_DATA_BITS-1:0] data12;
   logic                     tick;

   assign sample_ready = (state == IDLE);

   generate
      if (SINE_SIZE > DAC_DATA_BITS) begin : g_trunc
         logic unused_lsbs;
         assign unused_lsbs = ^sample[SINE_SIZE-DAC_DATA_BITS-1:0];
         assign data12 = sample[SINE_SIZE-1 -: DAC_DATA_BITS];
      end else if (SINE_SIZE == DAC_DATA_BITS) begin : g_exact
         assign data12 = sample;
      end else begin : g_pad
         assign data12 = {sample, {(DAC_DATA_BITS-SINE_SIZE){1'b0}}};
      end
   endgenerate

   // Holding the divider in restart while idle makes every state entry start from count 0.
   spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
      .clock   (clock),
      .reset   (reset),
      .restart (sample_ready),
      .tick    (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (sample_valid) begin
               shreg   <= {CTRL_BITS, data12};
               mosi    <= CTRL_BITS[3];
               cs_n    <= 1'b0;
               sclk    <= 1'b0;
               busy    <= 1'b1;
               bit_cnt <= '0;
               state   <= SETUP;
            end
            SETUP: if (tick) begin
               sclk  <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: if (tick) begin
               if (sclk) begin
                  sclk  <= 1'b0;
                  shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                  mosi  <= shreg[FRAME_BITS-2];
               end else if (bit_cnt == 4'd15) begin
                  bit_cnt <= '0;
                  cs_n    <= 1'b1;
                  mosi    <= 1'b0;
                  state   <= HOLD;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                  sclk    <= 1'b1;
               end
            end
            HOLD: if (tick) begin
               busy       <= 1'b0;
               frame_done <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: four instances with different widths and dividers, a DAC model
// monitor that rebuilds each frame from sclk/mosi, and a word model computed from the width rule.
`timescale 1ns/1ps
module tb_dac_spi_tx;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [13:0] smp [N];
   logic vld [N];
   logic rdy [N];
   logic sclk [N];
   logic mosi [N];
   logic cs_n [N];
   logic busy [N];
   logic fdone [N];

   int n_checks = 0;
   int n_fail = 0;
   logic [15:0] exp_q [N][$];
   logic abort [N];
   int rises [N];
   int frames_sent [N];
   int frames_done [N];

   dac_spi_tx #(.SINE_SIZE(12), .CLK_DIV(4)) u_main (
      .clock(clock), .reset(reset), .sample(smp[0][11:0]), .sample_valid(vld[0]),
      .sample_ready(rdy[0]), .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]),
      .busy(busy[0]), .frame_done(fdone[0]));
   dac_spi_tx #(.SINE_SIZE(8), .CLK_DIV(2)) u_w8 (
      .clock(clock), .reset(reset), .sample(smp[1][7:0]), .sample_valid(vld[1]),
      .sample_ready(rdy[1]), .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]),
      .busy(busy[1]), .frame_done(fdone[1]));
   dac_spi_tx #(.SINE_SIZE(14), .CLK_DIV(3)) u_w14 (
      .clock(clock), .reset(reset), .sample(smp[2]), .sample_valid(vld[2]),
      .sample_ready(rdy[2]), .sclk(sclk[2]), .mosi(mosi[2]), .cs_n(cs_n[2]),
      .busy(busy[2]), .frame_done(fdone[2]));
   dac_spi_tx #(.SINE_SIZE(12), .CLK_DIV(1)) u_d1 (
      .clock(clock), .reset(reset), .sample(smp[3][11:0]), .sample_valid(vld[3]),
      .sample_ready(rdy[3]), .sclk(sclk[3]), .mosi(mosi[3]), .cs_n(cs_n[3]),
      .busy(busy[3]), .frame_done(fdone[3]));

   function automatic int div_of(int i);
      case (i)
         0: return 4;
         1: return 2;
         2: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int sw_of(int i);
      case (i)
         1: return 8;
         2: return 14;
         default: return 12;
      endcase
   endfunction

   // Frame the DAC should receive: 0x3000 control nibble plus the sample scaled to 12 bits.
   function automatic logic [15:0] exp_word(int w, logic [13:0] s);
      int v;
      int d;
      v = int'(s) % (1 << w);
      if (w < 12) d = v * (1 << (12 - w));
      else        d = v / (1 << (w - 12));
      return 16'(12288 + d);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic timeout(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   task automatic monitor();
      logic [15:0] word [N];
      int bits [N];
      int low_cnt [N];
      int since_rise [N];
      logic prev_sclk [N];
      logic prev_cs [N];
      logic prev_mosi [N];
      for (int i = 0; i < N; i++) begin
         word[i] = '0; bits[i] = 0; low_cnt[i] = 0; since_rise[i] = 0;
         prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; prev_mosi[i] = 1'b0;
      end
      forever begin
         @(negedge clock);
         for (int i = 0; i < N; i++) begin
            since_rise[i]++;
            if (!cs_n[i] && prev_cs[i]) begin
               bits[i] = 0; word[i] = '0; rises[i] = 0;
            end
            if (!cs_n[i] && sclk[i] && !prev_sclk[i]) begin
               if (rises[i] > 0)
                  check($sformatf("sclk_period[%0d]", i), since_rise[i], 2 * div_of(i));
               check($sformatf("mosi_stable_at_rise[%0d]", i), mosi[i], prev_mosi[i]);
               word[i] = {word[i][14:0], mosi[i]};
               bits[i]++;
               rises[i]++;
               since_rise[i] = 0;
            end
            if (cs_n[i] && !prev_cs[i]) begin
               if (abort[i]) begin
                  check($sformatf("aborted_frame_bits[%0d]", i), bits[i], 7);
               end else if (exp_q[i].size() == 0) begin
                  timeout($sformatf("unexpected_frame[%0d]", i));
               end else begin
                  check($sformatf("dac_word[%0d]", i), word[i], exp_q[i].pop_front());
                  check($sformatf("dac_bits[%0d]", i), bits[i], 16);
               end
            end
            if (!rdy[i]) begin
               low_cnt[i]++;
            end else if (low_cnt[i] > 0) begin
               if (abort[i]) begin
                  check($sformatf("no_frame_done_on_abort[%0d]", i), fdone[i], 1'b0);
                  abort[i] = 1'b0;
               end else begin
                  check($sformatf("frame_cycles[%0d]", i), low_cnt[i], 34 * div_of(i));
                  check($sformatf("frame_done_pulse[%0d]", i), fdone[i], 1'b1);
                  check($sformatf("sclk_rises[%0d]", i), rises[i], 16);
                  frames_done[i]++;
               end
               low_cnt[i] = 0;
            end else begin
               check($sformatf("stray_frame_done[%0d]", i), fdone[i], 1'b0);
            end
            check($sformatf("busy_vs_ready[%0d]", i), busy[i], !rdy[i]);
            prev_sclk[i] = sclk[i];
            prev_cs[i]   = cs_n[i];
            prev_mosi[i] = mosi[i];
         end
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(int i, logic [13:0] v);
      int guard = 0;
      smp[i] = v;
      vld[i] = 1'b1;
      while (!rdy[i] && guard < 2000) begin
         @(posedge clock); #1;
         guard++;
      end
      if (!rdy[i]) timeout($sformatf("send_ready[%0d]", i));
      else begin
         exp_q[i].push_back(exp_word(sw_of(i), v));
         frames_sent[i]++;
      end
      @(posedge clock); #1;
      vld[i] = 1'b0;
      smp[i] = 14'($urandom);
   endtask

   task automatic stream2(int i, logic [13:0] a, logic [13:0] b);
      int guard = 0;
      int hold_hi = 0;
      smp[i] = a;
      vld[i] = 1'b1;
      while (!rdy[i] && guard < 2000) begin
         @(posedge clock); #1;
         guard++;
      end
      exp_q[i].push_back(exp_word(sw_of(i), a));
      frames_sent[i]++;
      @(posedge clock); #1;
      smp[i] = b;
      guard = 0;
      while (!rdy[i] && guard < 2000) begin
         if (cs_n[i] && busy[i]) hold_hi++;
         @(posedge clock); #1;
         guard++;
      end
      if (!rdy[i]) timeout($sformatf("b2b_ready[%0d]", i));
      else begin
         check($sformatf("b2b_frame_done_at_accept[%0d]", i), fdone[i], 1'b1);
         check($sformatf("b2b_cs_high_hold[%0d]", i), hold_hi, div_of(i));
         exp_q[i].push_back(exp_word(sw_of(i), b));
         frames_sent[i]++;
      end
      @(posedge clock); #1;
      check($sformatf("b2b_second_frame_started[%0d]", i), cs_n[i], 1'b0);
      vld[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      bit pending = 1'b1;
      while (pending && guard < 5000) begin
         pending = 1'b0;
         for (int i = 0; i < N; i++)
            if (!rdy[i] || exp_q[i].size() != 0) pending = 1'b1;
         if (pending) begin
            @(posedge clock); #1;
            guard++;
         end
      end
      if (pending) timeout("wait_idle");
      repeat (2) @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         smp[i] = '0; vld[i] = 1'b0; abort[i] = 1'b0;
         rises[i] = 0; frames_sent[i] = 0; frames_done[i] = 0;
      end
      #1 reset = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("reset_cs_n[%0d]", i), cs_n[i], 1'b1);
         check($sformatf("reset_sclk[%0d]", i), sclk[i], 1'b0);
         check($sformatf("reset_mosi[%0d]", i), mosi[i], 1'b0);
         check($sformatf("reset_busy[%0d]", i), busy[i], 1'b0);
         check($sformatf("reset_ready[%0d]", i), rdy[i], 1'b1);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      check("post_reset_ready", rdy[0], 1'b1);
      check("post_reset_cs_n", cs_n[0], 1'b1);

      send(0, 14'hA5C);
      wait_idle();

      stream2(0, 14'h000, 14'hFFF);
      wait_idle();

      // Abort a frame after its 7th sclk rise with an asynchronous reset.
      send(0, 14'($urandom));
      begin
         int guard = 0;
         @(negedge clock); #1;
         while (rises[0] < 7 && guard < 2000) begin
            @(negedge clock); #1;
            guard++;
         end
         if (rises[0] < 7) timeout("wait_7th_rise");
         check("sclk_high_before_abort", sclk[0], 1'b1);
         abort[0] = 1'b1;
         void'(exp_q[0].pop_back());
         frames_sent[0]--;
         reset = 1'b1;
         #1;
         check("abort_cs_n_immediate", cs_n[0], 1'b1);
         check("abort_sclk_immediate", sclk[0], 1'b0);
         @(posedge clock); @(posedge clock); #1;
         reset = 1'b0;
      end
      @(posedge clock); #1;
      send(0, 14'($urandom));
      wait_idle();

      send(1, 14'h00C3);
      send(2, 14'h3FFF);
      send(3, 14'h001);
      wait_idle();

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clock);
            #1;
            send(i, 14'($urandom));
         end
      end
      stream2(3, 14'($urandom), 14'($urandom));
      stream2(2, 14'($urandom), 14'($urandom));
      wait_idle();

      for (int i = 0; i < N; i++)
         check($sformatf("frames_completed[%0d]", i), frames_done[i], frames_sent[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
